// File: rtl/cdm8_seq_ctrl.sv
// Sequencing controller: drives one shared 8x4 partial-product unit twice
// (low nibble, then high nibble) and accumulates a 16-bit 8x8 product.
module cdm8_seq_ctrl #(
    parameter logic LOW_SEL  = 1'b1,
    parameter logic HIGH_SEL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [7:0]  pp_a,
    output logic [3:0]  pp_b,
    output logic        pp_sel,
    input  logic [11:0] pp_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_r,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  a_reg, b_reg;
    logic [15:0] acc;
    logic        accept;

    // DONE can hand off the product and take new operands on the same edge
    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign out_r     = acc;

    always_comb begin
        state_nxt = state;
        pp_a      = '0;
        pp_b      = '0;
        pp_sel    = LOW_SEL;
        case (state)
            IDLE: begin
                if (accept) state_nxt = LOW;
            end
            LOW: begin
                pp_a   = a_reg;
                pp_b   = b_reg[3:0];
                pp_sel = LOW_SEL;
                // a zero high nibble contributes nothing, so skip that pass
                state_nxt = (b_reg[7:4] != 4'd0) ? HIGH : DONE;
            end
            HIGH: begin
                pp_a      = a_reg;
                pp_b      = b_reg[7:4];
                pp_sel    = HIGH_SEL;
                state_nxt = DONE;
            end
            DONE: begin
                if (accept)         state_nxt = LOW;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            op_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_reg <= in_a;
                b_reg <= in_b;
            end
            if (state == LOW)
                acc <= {4'b0, pp_r};
            else if (state == HIGH)
                acc <= acc + {pp_r, 4'b0};
            if ((state == DONE) && out_ready)
                op_count <= op_count + 16'd1;
        end
    end

endmodule

// File: doc/cdm8_seq_ctrl.md
# cdm8_seq_ctrl

Sequencing controller that time-shares one 8x4 carry-disregard partial-product unit to compute 8x8 approximate products over multiple cycles. It accepts operands through a valid/ready handshake and drives the shared unit twice: low multiplier nibble first, then high nibble. It accumulates the shifted 12-bit partial results into a 16-bit product and returns it through a second valid/ready handshake. It sits between an operand source and the shared 8x4 unit, and replaces the two-unit parallel 8x8 multiplier where area matters more than throughput.

## Interface
- LOW_SEL, 1'b1, pp_sel value driven while the low nibble (B[3:0]) is applied (higher-approximation unit configuration)
- HIGH_SEL, 1'b0, pp_sel value driven while the high nibble (B[7:4]) is applied (low/no-approximation configuration)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  controller can accept operands this cycle
- in_a  in  8  multiplicand
- in_b  in  8  multiplier
- pp_a  out  8  multiplicand to shared 8x4 unit
- pp_b  out  4  multiplier nibble to shared 8x4 unit
- pp_sel  out  1  approximation-level select to shared unit
- pp_r  in  12  combinational 8x4 partial product from shared unit (same-cycle)
- out_valid  out  1  product available
- out_ready  in  1  consumer takes product this cycle
- out_r  out  16  product
- op_count  out  16  completed transactions, wraps 0xFFFF -> 0x0000

## Operation
- FSM states: IDLE, LOW, HIGH, DONE; registers a_reg[7:0], b_reg[7:0], acc[15:0].
- in_ready = (state==IDLE) | (state==DONE & out_ready), combinational.
- Accept = in_valid & in_ready: latch a_reg=in_a, b_reg=in_b, go to LOW.
- IDLE: pp_a=0, pp_b=0, pp_sel=LOW_SEL; stay until accept.
- LOW: pp_a=a_reg, pp_b=b_reg[3:0], pp_sel=LOW_SEL.
  - At edge: acc = {4'b0, pp_r}.
  - Next state is HIGH if b_reg[7:4] != 0; otherwise DONE (high-nibble skip).
- HIGH: pp_a=a_reg, pp_b=b_reg[7:4], pp_sel=HIGH_SEL.
  - At edge: acc = acc + {pp_r, 4'b0}, modulo 2^16; carry out is discarded.
  - Next state DONE.
- DONE: out_valid=1, out_r=acc.
  - On out_ready: op_count += 1.
  - Then go to LOW if an accept occurs the same cycle, else IDLE.
- out_r holds acc at all times. It must remain stable while out_valid=1 and out_ready=0.
- pp_r is sampled only in LOW and HIGH. pp_r is ignored elsewhere and may be X.
- in_a/in_b changes while not accepted have no effect.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_r=0, pp_a=0, pp_b=0, pp_sel=LOW_SEL, op_count=0, a_reg=b_reg=acc=0.
- Reset is applied mid-operation in any state: the transaction is abandoned with no output. Reset values appear in the cycle after the reset edge.
- Latency: accept at edge k -> LOW in cycle k+1 -> HIGH in k+2 -> out_valid=1 in cycle k+3.
- With high-nibble skip: out_valid=1 in cycle k+2.
- Back-to-back throughput with out_ready=1: one product per 3 cycles, or per 2 cycles with skip. No idle bubble, because DONE accepts new operands directly.
- Simultaneous out_ready and in_valid in DONE: the product is delivered and new operands are accepted on the same edge.
- in_valid in LOW/HIGH: in_ready=0; the source holds.
- No combinational path from in_valid to out_valid. The only combinational path from out_ready is to in_ready.

## Test plan
Bench model for these directed tests: pp_r = pp_a * pp_b (exact), pp_sel checked against its sequence.
- Basic full product: in_a=0xFF, in_b=0xFF accepted at edge k.
  - pp_sel=1 in k+1, then 0 in k+2.
  - out_valid=1 in k+3 with out_r=0xFE01; op_count=1 after out_ready.
- Skip: in_a=0x12, in_b=0x05 -> out_valid in k+2 with out_r=0x005A. HIGH is never entered (pp_sel never equals HIGH_SEL).
- Backpressure: in_a=0x80, in_b=0x40, out_ready=0 for 5 cycles.
  - out_r=0x2000 stable, out_valid=1, in_ready=0 throughout.
  - Release -> one transfer only.
- Back-to-back: in_valid held with (0x03,0x21) then (0x10,0x10), out_ready=1.
  - Products 0x0063 then 0x0100, 3 cycles apart; in_ready=1 in each DONE cycle.
- Reset mid-op: assert rst during HIGH of (0xAA,0xBB).
  - Next cycle: out_valid=0, in_ready=1, out_r=0, op_count=0.
  - A following (0x02,0x03) yields 0x0006.
- Zero operands: in_a=0x00, in_b=0x00 -> out_r=0x0000 via skip path in k+2. Then in_a=0x07, in_b=0xF0 -> low pass gives acc=0, result 0x0690.
